// File: rtl/wload_pkg.sv
// -----------------------------------------------------------------------------
// wload_pkg
// Shared definitions for the weight load sequencer:
//   - wload_state_t : sequencer state encoding
//   - FIELD_W       : width of one per-layer field in the packed parameters
//   - PARAM_VEC_W   : widest packed parameter vector field_at() accepts
//   - field_at()    : extracts field <idx> from a packed per-layer parameter
// No ports (package).
// -----------------------------------------------------------------------------
package wload_pkg;

    localparam int FIELD_W     = 16;
    localparam int PARAM_VEC_W = 256;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_W   = 3'd1,
        LD_B   = 3'd2,
        LD_C   = 3'd3,
        LD_SUM = 3'd4,
        DONE   = 3'd5
    } wload_state_t;

    // Layer 0 sits in the least significant field of the packed vector.
    function automatic logic [FIELD_W-1:0] field_at(input logic [PARAM_VEC_W-1:0] vec,
                                                    input int idx);
        return vec[idx*FIELD_W +: FIELD_W];
    endfunction

endpackage

// File: rtl/wload_px_gate.sv
// -----------------------------------------------------------------------------
// wload_px_gate
// Pixel path gate between the pixel source and the conv model. Pixels only
// pass once parameters are loaded and while the model FIFO can take them.
// Ports:
//   load_done  in   1      parameters loaded, pixel path may open
//   fifo_rd_en in   1      model input-FIFO read permission
//   px_data    in   PIX_W  pixel source data
//   px_valid   in   1      pixel source valid
//   px_ready   out  1      pixel source ready
//   i_data     out  PIX_W  pixel data to model
//   i_valid    out  1      pixel valid to model
// -----------------------------------------------------------------------------
module wload_px_gate #(
    parameter int PIX_W = 16
) (
    input  logic             load_done,
    input  logic             fifo_rd_en,
    input  logic [PIX_W-1:0] px_data,
    input  logic             px_valid,
    output logic             px_ready,
    output logic [PIX_W-1:0] i_data,
    output logic             i_valid
);

    assign px_ready = load_done & fifo_rd_en;
    assign i_valid  = px_valid & px_ready;
    assign i_data   = px_data;

endmodule

// File: rtl/weight_load_seq.sv
// -----------------------------------------------------------------------------
// weight_load_seq
// Streams parameter words into the conv model. Each layer receives NW weight
// words, NB bias words and one coefficient word at addresses
// base+0.., base+NW.., base+NW+NB. After the last layer the pixel path opens.
//
// Optional feature macro: WLOAD_CHECKSUM_EN
//   When defined, one trailer word follows the last coefficient. It must equal
//   the 32-bit wrap-around sum of all earlier accepted words; otherwise the
//   sticky csum_err output is raised. The trailer is never written to the model.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           begin a full load (ignored while busy)
//   s_wdata/s_wvalid/s_wready       32-bit parameter word stream
//   weight_wr_data/addr/en          write port into the model
//   busy                            load sequence in progress
//   load_done                       all layers loaded, pixel path open
//   layer_idx                       layer currently loading
//   csum_err                        checksum mismatch (WLOAD_CHECKSUM_EN only)
//   px_data/px_valid/px_ready       pixel source handshake
//   fifo_rd_en                      model input-FIFO read permission
//   i_data/i_valid                  pixels into the model
// -----------------------------------------------------------------------------
module weight_load_seq
    import wload_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int PIX_W      = 16,
    parameter logic [FIELD_W*NUM_LAYERS-1:0] LAYER_BASE = {16'd130, 16'd54, 16'd40, 16'd0},
    parameter logic [FIELD_W*NUM_LAYERS-1:0] LAYER_NW   = {16'd4, 16'd72, 16'd8, 16'd36},
    parameter logic [FIELD_W*NUM_LAYERS-1:0] LAYER_NB   = {16'd2, 16'd2, 16'd4, 16'd2},
    localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [31:0]        s_wdata,
    input  logic               s_wvalid,
    output logic               s_wready,
    output logic [31:0]        weight_wr_data,
    output logic [31:0]        weight_wr_addr,
    output logic               weight_wr_en,
    output logic               busy,
    output logic               load_done,
    output logic [LAYER_W-1:0] layer_idx,
`ifdef WLOAD_CHECKSUM_EN
    output logic               csum_err,
`endif
    input  logic [PIX_W-1:0]   px_data,
    input  logic               px_valid,
    output logic               px_ready,
    input  logic               fifo_rd_en,
    output logic [PIX_W-1:0]   i_data,
    output logic               i_valid
);

    // Empty weight or bias sections would break the count-to-last exits.
    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_param_chk
        if (LAYER_NW[g*FIELD_W +: FIELD_W] == '0) begin : g_nw_zero
            $error("weight_load_seq: LAYER_NW of layer %0d must be >= 1", g);
        end
        if (LAYER_NB[g*FIELD_W +: FIELD_W] == '0) begin : g_nb_zero
            $error("weight_load_seq: LAYER_NB of layer %0d must be >= 1", g);
        end
    end

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    wload_state_t         state, state_nx;
    logic [LAYER_W-1:0]   layer, layer_nx;
    logic [FIELD_W-1:0]   cnt, cnt_nx;
    logic [FIELD_W-1:0]   cur_base, cur_nw, cur_nb, offset;
    logic                 accept;
    logic                 write_now;
    logic                 start_go;

    // Stream is only open while a load state is waiting for words.
    always_comb begin
        s_wready = 1'b0;
        case (state)
            LD_W, LD_B, LD_C: s_wready = 1'b1;
`ifdef WLOAD_CHECKSUM_EN
            LD_SUM:           s_wready = 1'b1;
`endif
            default:          s_wready = 1'b0;
        endcase
    end

    assign accept    = s_wvalid & s_wready;
    assign write_now = accept & (state != LD_SUM);
    // busy also covers the one cycle after the final write, so a start there is ignored.
    assign start_go  = start & ~busy & ((state == IDLE) | (state == DONE));

    // Current layer's address map and the offset of the word being accepted.
    always_comb begin
        cur_base = field_at(PARAM_VEC_W'(LAYER_BASE), int'(layer));
        cur_nw   = field_at(PARAM_VEC_W'(LAYER_NW), int'(layer));
        cur_nb   = field_at(PARAM_VEC_W'(LAYER_NB), int'(layer));
        offset   = '0;
        case (state)
            LD_W:    offset = cnt;
            LD_B:    offset = cur_nw + cnt;
            LD_C:    offset = cur_nw + cur_nb;
            default: offset = '0;
        endcase
    end

    // Next-state logic: each load state counts accepted words and leaves on the last one.
    always_comb begin
        state_nx = state;
        layer_nx = layer;
        cnt_nx   = cnt;
        case (state)
            IDLE, DONE: begin
                if (start_go) begin
                    state_nx = LD_W;
                    layer_nx = '0;
                    cnt_nx   = '0;
                end
            end
            LD_W: begin
                if (accept) begin
                    if (cnt == cur_nw - 16'd1) begin
                        state_nx = LD_B;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
            end
            LD_B: begin
                if (accept) begin
                    if (cnt == cur_nb - 16'd1) begin
                        state_nx = LD_C;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                end
            end
            LD_C: begin
                if (accept) begin
                    cnt_nx = '0;
                    if (layer == LAST_LAYER) begin
`ifdef WLOAD_CHECKSUM_EN
                        state_nx = LD_SUM;
`else
                        state_nx = DONE;
`endif
                    end else begin
                        layer_nx = layer + 1'b1;
                        state_nx = LD_W;
                    end
                end
            end
            LD_SUM: begin
                if (accept) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            layer <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            layer <= layer_nx;
            cnt   <= cnt_nx;
        end
    end

    // Write port is registered: accepted word appears one cycle later; addr/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_wr_en   <= 1'b0;
            weight_wr_addr <= '0;
            weight_wr_data <= '0;
        end else begin
            weight_wr_en <= write_now;
            if (write_now) begin
                weight_wr_addr <= {16'd0, cur_base + offset};
                weight_wr_data <= s_wdata;
            end
        end
    end

    // busy trails the load states by one cycle at the end; load_done rises as busy falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            busy      <= start_go | (state == LD_W) | (state == LD_B) |
                         (state == LD_C) | (state == LD_SUM);
            load_done <= (state == DONE) & ~start_go;
        end
    end

    assign layer_idx = layer;

`ifdef WLOAD_CHECKSUM_EN
    logic [31:0] csum;

    // Running sum of data words; the trailer is compared against it, not added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum     <= '0;
            csum_err <= 1'b0;
        end else if (start_go) begin
            csum     <= '0;
            csum_err <= 1'b0;
        end else if (accept) begin
            if (state == LD_SUM) begin
                if (s_wdata != csum) begin
                    csum_err <= 1'b1;
                end
            end else begin
                csum <= csum + s_wdata;
            end
        end
    end
`endif

    wload_px_gate #(
        .PIX_W(PIX_W)
    ) u_px_gate (
        .load_done (load_done),
        .fifo_rd_en(fifo_rd_en),
        .px_data   (px_data),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .i_data    (i_data),
        .i_valid   (i_valid)
    );

endmodule

// File: tb/tb_weight_load_seq.sv
// -----------------------------------------------------------------------------
// tb_weight_load_seq
// Randomised bench for weight_load_seq with an in-bench reference model built
// from the layer address map (a flat list of expected write addresses).
// Honours WLOAD_CHECKSUM_EN when defined.
// -----------------------------------------------------------------------------
module tb_weight_load_seq;

    localparam int PIX_W      = 16;
    localparam int NUM_LAYERS = 4;

    int bases [NUM_LAYERS] = '{0, 40, 54, 130};
    int nws   [NUM_LAYERS] = '{36, 8, 72, 4};
    int nbs   [NUM_LAYERS] = '{2, 4, 2, 2};

`ifdef WLOAD_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [31:0]      s_wdata;
    logic             s_wvalid;
    logic             s_wready;
    logic [31:0]      weight_wr_data;
    logic [31:0]      weight_wr_addr;
    logic             weight_wr_en;
    logic             busy;
    logic             load_done;
    logic [1:0]       layer_idx;
`ifdef WLOAD_CHECKSUM_EN
    logic             csum_err;
`endif
    logic [PIX_W-1:0] px_data;
    logic             px_valid;
    logic             px_ready;
    logic             fifo_rd_en;
    logic [PIX_W-1:0] i_data;
    logic             i_valid;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    int          exp_addr[$];
    int          total;
    bit          m_load, m_busy, m_done, m_wr_en, m_err;
    int          m_k;
    logic [31:0] m_addr, m_data, m_sum;
    bit          csum_bad = 1'b0;

    // Write statistics observed on the DUT write port
    int write_count;
    int first_addr;
    int last_addr;
    bit hit[256];

    weight_load_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .s_wdata       (s_wdata),
        .s_wvalid      (s_wvalid),
        .s_wready      (s_wready),
        .weight_wr_data(weight_wr_data),
        .weight_wr_addr(weight_wr_addr),
        .weight_wr_en  (weight_wr_en),
        .busy          (busy),
        .load_done     (load_done),
        .layer_idx     (layer_idx),
`ifdef WLOAD_CHECKSUM_EN
        .csum_err      (csum_err),
`endif
        .px_data       (px_data),
        .px_valid      (px_valid),
        .px_ready      (px_ready),
        .fifo_rd_en    (fifo_rd_en),
        .i_data        (i_data),
        .i_valid       (i_valid)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int layer_of(input int k);
        int acc = 0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            acc += nws[l] + nbs[l] + 1;
            if (k < acc) return l;
        end
        return NUM_LAYERS - 1;
    endfunction

    task automatic model_reset();
        m_load  = 1'b0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_wr_en = 1'b0;
        m_err   = 1'b0;
        m_k     = 0;
        m_addr  = '0;
        m_data  = '0;
        m_sum   = '0;
    endtask

    task automatic clear_stats();
        write_count = 0;
        first_addr  = -1;
        last_addr   = -1;
        for (int i = 0; i < 256; i++) hit[i] = 1'b0;
    endtask

    // Per-cycle compare against the model, then advance the model by one clock edge.
    initial begin
        bit acc;
        model_reset();
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                model_reset();
                check_output("rst_wr_en", 32'(weight_wr_en), 32'd0);
                check_output("rst_wr_addr", weight_wr_addr, 32'd0);
                check_output("rst_wr_data", weight_wr_data, 32'd0);
                check_output("rst_busy", 32'(busy), 32'd0);
                check_output("rst_load_done", 32'(load_done), 32'd0);
                check_output("rst_s_wready", 32'(s_wready), 32'd0);
                check_output("rst_layer_idx", 32'(layer_idx), 32'd0);
                check_output("rst_i_valid", 32'(i_valid), 32'd0);
            end else begin
                check_output("s_wready", 32'(s_wready), 32'(m_load));
                check_output("busy", 32'(busy), 32'(m_busy));
                check_output("load_done", 32'(load_done), 32'(m_done));
                check_output("wr_en", 32'(weight_wr_en), 32'(m_wr_en));
                check_output("wr_addr", weight_wr_addr, m_addr);
                check_output("wr_data", weight_wr_data, m_data);
                if (m_load) check_output("layer_idx", 32'(layer_idx), 32'(layer_of(m_k)));
                check_output("px_ready", 32'(px_ready), 32'(m_done & fifo_rd_en));
                check_output("i_valid", 32'(i_valid), 32'(m_done & fifo_rd_en & px_valid));
                check_output("i_data", 32'(i_data), 32'(px_data));
`ifdef WLOAD_CHECKSUM_EN
                check_output("csum_err", 32'(csum_err), 32'(m_err));
`endif
                if (weight_wr_en) begin
                    if (write_count == 0) first_addr = int'(weight_wr_addr);
                    last_addr = int'(weight_wr_addr);
                    if (weight_wr_addr < 32'd256) hit[weight_wr_addr[7:0]] = 1'b1;
                    write_count++;
                end
                acc = m_load && s_wvalid;
                m_wr_en = acc && (m_k < total);
                if (m_wr_en) begin
                    m_addr = 32'(exp_addr[m_k]);
                    m_data = s_wdata;
                    m_sum  = m_sum + s_wdata;
                end
                if (acc && m_k == total && s_wdata != m_sum) m_err = 1'b1;
                if (!m_busy && start) begin
                    m_load = 1'b1;
                    m_k    = 0;
                    m_busy = 1'b1;
                    m_done = 1'b0;
                    m_sum  = '0;
                    m_err  = 1'b0;
                end else if (m_load) begin
                    if (acc) begin
                        m_k++;
                        if (m_k == total + EXTRA) m_load = 1'b0;
                    end
                end else if (m_busy) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    // One cycle of stimulus. Decisions that depend on load progress use the model's word count.
    task automatic apply_stimulus(input int mode, input bit force_start, input int mid_start_k,
                                  input int reset_k);
        @(negedge clk);
        start = force_start | (m_load && m_k == mid_start_k);
        case (mode)
            0:       s_wvalid = 1'b1;
            1:       s_wvalid = ~s_wvalid;
            default: s_wvalid = 1'($urandom_range(0, 1));
        endcase
        s_wdata = $urandom;
        if (m_load && m_k == total) s_wdata = m_sum + 32'(csum_bad);
        px_valid   = 1'($urandom_range(0, 1));
        px_data    = PIX_W'($urandom);
        fifo_rd_en = 1'($urandom_range(0, 1));
        if (m_load && m_k == reset_k) rst_n = 1'b0;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        start      = 1'b0;
        s_wvalid   = 1'b0;
        px_valid   = 1'b0;
        fifo_rd_en = 1'b0;
    endtask

    // Full load: start pulse, stream until load_done (bounded) or until a planted reset.
    task automatic run_load(input int mode, input int mid_start_k, input int reset_k);
        bit finished = 1'b0;
        apply_stimulus(mode, 1'b1, -1, -1);
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus(mode, 1'b0, mid_start_k, reset_k);
            if (!rst_n) begin
                repeat (2) @(negedge clk);
                start    = 1'b0;
                s_wvalid = 1'b0;
                rst_n    = 1'b1;
                return;
            end
            #1;
            if (load_done) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check_output("load_timeout", 32'd0, 32'd1);
        idle_inputs();
    endtask

    task automatic pix_probe(input bit v, input bit f, input logic [PIX_W-1:0] d,
                             input bit exp_valid, input string name);
        @(negedge clk);
        start      = 1'b0;
        s_wvalid   = 1'b0;
        px_valid   = v;
        fifo_rd_en = f;
        px_data    = d;
        #1;
        check_output({name, "_i_valid"}, 32'(i_valid), 32'(exp_valid));
        check_output({name, "_px_ready"}, 32'(px_ready), 32'(exp_valid));
        check_output({name, "_i_data"}, 32'(i_data), 32'(d));
    endtask

    initial begin
        foreach (bases[l]) begin
            for (int w = 0; w < nws[l] + nbs[l] + 1; w++) exp_addr.push_back(bases[l] + w);
        end
        total = exp_addr.size();

        rst_n      = 1'b0;
        start      = 1'b0;
        s_wdata    = '0;
        s_wvalid   = 1'b0;
        px_data    = '0;
        px_valid   = 1'b0;
        fifo_rd_en = 1'b0;
        clear_stats();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Pin the address map with hand-computed values.
        check_output("map_total", 32'(total), 32'd134);
        check_output("map_38", 32'(exp_addr[38]), 32'd38);
        check_output("map_39", 32'(exp_addr[39]), 32'd40);
        check_output("map_52", 32'(exp_addr[52]), 32'd54);
        check_output("map_133", 32'(exp_addr[133]), 32'd136);

        $display("[TB] pixel path closed before load");
        pix_probe(1'b1, 1'b1, 16'h1234, 1'b0, "pre_load");

        $display("[TB] load 1: back-to-back stream");
        clear_stats();
        run_load(0, -1, -1);
        check_output("l1_writes", 32'(write_count), 32'd134);
        check_output("l1_first", 32'(first_addr), 32'd0);
        check_output("l1_last", 32'(last_addr), 32'd136);
        check_output("l1_gap39", 32'(hit[39]), 32'd0);
        check_output("l1_gap53", 32'(hit[53]), 32'd0);
        check_output("l1_gap129", 32'(hit[129]), 32'd0);
        check_output("l1_done", 32'(load_done), 32'd1);
        check_output("l1_busy", 32'(busy), 32'd0);
`ifdef WLOAD_CHECKSUM_EN
        check_output("l1_csum_err", 32'(csum_err), 32'd0);
`endif
        pix_probe(1'b1, 1'b0, 16'h5A5A, 1'b0, "done_no_fifo");
        pix_probe(1'b1, 1'b1, 16'hA5C3, 1'b1, "done_fifo");

        $display("[TB] load 2: toggling valid, start pulse mid-load");
        clear_stats();
        s_wvalid = 1'b0;
        run_load(1, 10, -1);
        check_output("l2_writes", 32'(write_count), 32'd134);
        check_output("l2_last", 32'(last_addr), 32'd136);

        $display("[TB] load 3: random stall, reset mid-load");
        run_load(2, -1, 20);
        @(negedge clk);
        #1;
        check_output("abort_wr_en", 32'(weight_wr_en), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(load_done), 32'd0);

        $display("[TB] load 4: random stall after reset");
        clear_stats();
        run_load(2, -1, -1);
        check_output("l4_first", 32'(first_addr), 32'd0);
        check_output("l4_writes", 32'(write_count), 32'd134);

`ifdef WLOAD_CHECKSUM_EN
        $display("[TB] load 5: corrupted checksum trailer");
        csum_bad = 1'b1;
        run_load(2, -1, -1);
        check_output("l5_csum_err", 32'(csum_err), 32'd1);
        check_output("l5_done", 32'(load_done), 32'd1);
        csum_bad = 1'b0;
`endif

        repeat (3) idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
